// File: rtl/rect_stream_pkg.sv
// Shared types, field indices and the coordinate clamp for the rect copy link.
package rect_stream_pkg;

  localparam int unsigned WORDS_PER_RECT = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Field order is identical in the memory record and in the output stream.
  localparam logic [2:0] F_X     = 3'd0;
  localparam logic [2:0] F_Y     = 3'd1;
  localparam logic [2:0] F_W     = 3'd2;
  localparam logic [2:0] F_H     = 3'd3;
  localparam logic [2:0] F_COLOR = 3'(WORDS_PER_RECT - 1);

  // Clamp a signed coordinate into [0, 2^coord_width-1], zero-extended to 16 bits.
  // coord_width must not exceed 16.
  function automatic logic [15:0] clamp_coord(input logic signed [17:0] v,
                                              input int unsigned coord_width);
    logic [17:0] lim;
    lim = 18'((32'd1 << coord_width) - 32'd1);
    if (v < 0)
      clamp_coord = '0;
    else if ($unsigned(v) > lim)
      clamp_coord = lim[15:0];
    else
      clamp_coord = v[15:0];
  endfunction

endpackage

// File: rtl/rect_stream_tx_edge_calc.sv
// Combinational per-word conversion from a rect record field to an output edge.
module rect_edge_calc
  import rect_stream_pkg::*;
#(
  parameter int unsigned COORD_WIDTH = 11
) (
  input  logic [2:0]  i_field,
  input  logic [15:0] i_rdata,
  input  logic [15:0] i_x_hold,
  input  logic [15:0] i_y_hold,
  output logic [15:0] o_word
);

  logic signed [17:0] w_rd_s;
  logic signed [17:0] w_rd_u;
  logic signed [17:0] w_x_s;
  logic signed [17:0] w_y_s;
  logic signed [17:0] w_right;
  logic signed [17:0] w_bottom;

  // Select the conversion by field; sums carry one bit beyond 17 so that
  // 16'h7FFF + 16'hFFFF stays positive and clamps to the ceiling.
  always_comb begin
    w_rd_s   = {{2{i_rdata[15]}}, i_rdata};
    w_rd_u   = {2'b00, i_rdata};
    w_x_s    = {{2{i_x_hold[15]}}, i_x_hold};
    w_y_s    = {{2{i_y_hold[15]}}, i_y_hold};
    w_right  = w_x_s + w_rd_u;
    w_bottom = w_y_s + w_rd_u;
    case (i_field)
      F_X, F_Y: o_word = clamp_coord(w_rd_s, COORD_WIDTH);
      F_W:      o_word = clamp_coord(w_right, COORD_WIDTH);
      F_H:      o_word = clamp_coord(w_bottom, COORD_WIDTH);
      default:  o_word = i_rdata;
    endcase
  end

endmodule

// File: rtl/rect_stream_tx.sv
// Rect copy transmitter: reads RECT_COUNT records from data memory on a frame
// trigger and streams clamped edges to the GPU, stalling the CPU meanwhile.
module rect_stream_tx
  import rect_stream_pkg::*;
#(
  parameter int unsigned COORD_WIDTH = 11,
  parameter int unsigned RECT_COUNT  = 64,
  parameter logic [15:0] RECT_BASE   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic        cpu_stall,
  output logic        copy_start,
  output logic [15:0] dout,
  output logic        done
);

  localparam int unsigned RECT_W = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;

  state_t              r_state;
  logic [2:0]          r_field;
  logic [RECT_W-1:0]   r_rect;
  logic                r_drain;
  logic [15:0]         r_addr;
  logic                r_mem_rd;
  logic                r_stall;
  logic                r_copy_start;
  logic                r_done;

  logic                r_rd_d;
  logic [2:0]          r_field_d;
  logic [15:0]         r_x_hold;
  logic [15:0]         r_y_hold;
  logic [15:0]         r_dout;

  logic                w_last;
  logic [15:0]         w_word;

  assign w_last = (r_field == F_COLOR) && (r_rect == RECT_W'(RECT_COUNT - 1));

  // Frame FSM: counters, address generator and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_field      <= '0;
      r_rect       <= '0;
      r_drain      <= 1'b0;
      r_addr       <= '0;
      r_mem_rd     <= 1'b0;
      r_stall      <= 1'b0;
      r_copy_start <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_copy_start <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= READ;
            r_addr   <= RECT_BASE;
            r_mem_rd <= 1'b1;
            r_stall  <= 1'b1;
            r_field  <= '0;
            r_rect   <= '0;
          end
        end
        READ: begin
          // First read goes out this cycle, so its data appears on the next.
          r_copy_start <= (r_field == F_X) && (r_rect == '0);
          if (w_last) begin
            r_state  <= DRAIN;
            r_mem_rd <= 1'b0;
            r_field  <= '0;
            r_rect   <= '0;
            r_drain  <= 1'b0;
          end else begin
            r_addr <= r_addr + 16'd1;
            if (r_field == F_COLOR) begin
              r_field <= F_X;
              r_rect  <= r_rect + 1'b1;
            end else begin
              r_field <= r_field + 3'd1;
            end
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_stall <= 1'b0;
          r_drain <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data path: track which field is on mem_rdata, hold x/y, register the output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_d    <= 1'b0;
      r_field_d <= '0;
      r_x_hold  <= '0;
      r_y_hold  <= '0;
      r_dout    <= '0;
    end else begin
      r_rd_d    <= r_mem_rd;
      r_field_d <= r_field;
      if (r_rd_d) begin
        r_dout <= w_word;
        if (r_field_d == F_X) r_x_hold <= mem_rdata;
        if (r_field_d == F_Y) r_y_hold <= mem_rdata;
      end
    end
  end

  rect_edge_calc #(
    .COORD_WIDTH(COORD_WIDTH)
  ) u_calc (
    .i_field (r_field_d),
    .i_rdata (mem_rdata),
    .i_x_hold(r_x_hold),
    .i_y_hold(r_y_hold),
    .o_word  (w_word)
  );

  assign mem_addr   = r_addr;
  assign mem_rd     = r_mem_rd;
  assign cpu_stall  = r_stall;
  assign copy_start = r_copy_start;
  assign dout       = r_dout;
  assign done       = r_done;

endmodule

// File: tb/tb_rect_stream_tx.sv
// Scoreboard bench for rect_stream_tx: stimulus pushes expected events, a
// negedge monitor pops and compares them as the DUT produces them.
module tb_rect_stream_tx;

  localparam int unsigned CW   = 11;
  localparam int unsigned N    = 8;
  localparam logic [15:0] BASE = 16'hFFEC;
  localparam int unsigned NW   = 5 * N;
  localparam int          LIM  = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic        cpu_stall;
  logic        copy_start;
  logic [15:0] dout;
  logic        done;

  rect_stream_tx #(
    .COORD_WIDTH(CW),
    .RECT_COUNT (N),
    .RECT_BASE  (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .cpu_stall (cpu_stall),
    .copy_start(copy_start),
    .dout      (dout),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [15:0] addr;
  } rd_ev_t;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_w[$];
  rd_ev_t      exp_a[$];
  int unsigned exp_cs[$];
  int unsigned exp_d[$];
  bit          exp_stall [0:4095];

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          abort_req = 1'b0;
  int unsigned stream_left = 0;
  rd_ev_t      mon_ev;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data appears one cycle after the read.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > LIM) ? LIM : v);
  endfunction

  function automatic logic [15:0] rec_addr(input int unsigned i, input int unsigned f);
    return BASE + 16'(5 * i + f);
  endfunction

  // Reference: expected stream, read addresses, pulses and stall window for a frame started at s.
  task automatic expect_frame(input int unsigned s);
    logic [15:0] x, y, w, h, c;
    for (int unsigned i = 0; i < N; i++) begin
      x = mem[rec_addr(i, 0)];
      y = mem[rec_addr(i, 1)];
      w = mem[rec_addr(i, 2)];
      h = mem[rec_addr(i, 3)];
      c = mem[rec_addr(i, 4)];
      exp_w.push_back(16'(clampi(int'($signed(x)))));
      exp_w.push_back(16'(clampi(int'($signed(y)))));
      exp_w.push_back(16'(clampi(int'($signed(x)) + int'(w))));
      exp_w.push_back(16'(clampi(int'($signed(y)) + int'(h))));
      exp_w.push_back(c);
    end
    for (int unsigned k = 0; k < NW; k++) exp_a.push_back('{s + 1 + k, BASE + 16'(k)});
    exp_cs.push_back(s + 2);
    exp_d.push_back(s + NW + 3);
    for (int unsigned t = s + 1; t <= s + NW + 3; t++) exp_stall[t] = 1'b1;
  endtask

  function automatic logic [15:0] rand_coord();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 2400)) - 16'd200;
  endfunction

  task automatic fill_random();
    for (int unsigned i = 0; i < N; i++) begin
      mem[rec_addr(i, 0)] = rand_coord();
      mem[rec_addr(i, 1)] = rand_coord();
      mem[rec_addr(i, 2)] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 600));
      mem[rec_addr(i, 3)] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 600));
      mem[rec_addr(i, 4)] = 16'($urandom);
    end
  endtask

  task automatic set_rec(input int unsigned i, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] w, input logic [15:0] h, input logic [15:0] c);
    mem[rec_addr(i, 0)] = x;
    mem[rec_addr(i, 1)] = y;
    mem[rec_addr(i, 2)] = w;
    mem[rec_addr(i, 3)] = h;
    mem[rec_addr(i, 4)] = c;
  endtask

  task automatic pulse_frame();
    int unsigned s;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    expect_frame(s);
    @(negedge clk);
    start = 1'b0;
    repeat (NW + 6) @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (abort_req) begin
      exp_w.delete();
      exp_a.delete();
      exp_cs.delete();
      exp_d.delete();
      stream_left = 0;
      check("reset_mem_addr", mem_addr, 16'h0000);
      check("reset_mem_rd", mem_rd, 1'b0);
      check("reset_copy_start", copy_start, 1'b0);
      check("reset_dout", dout, 16'h0000);
      check("reset_done", done, 1'b0);
      abort_req = 1'b0;
    end
    if (stream_left > 0) begin
      if (exp_w.size() == 0) fail_now("dout_extra");
      else check("dout", dout, exp_w.pop_front());
      stream_left--;
    end
    if (copy_start) begin
      if (exp_cs.size() == 0) fail_now("copy_start_extra");
      else check("copy_start_cycle", cyc, exp_cs.pop_front());
      stream_left = NW;
    end
    if (mem_rd) begin
      if (exp_a.size() == 0) fail_now("mem_rd_extra");
      else begin
        mon_ev = exp_a.pop_front();
        check("mem_addr", mem_addr, mon_ev.addr);
        check("mem_rd_cycle", cyc, mon_ev.cyc);
      end
    end
    if (done) begin
      if (exp_d.size() == 0) fail_now("done_extra");
      else check("done_cycle", cyc, exp_d.pop_front());
    end
    if (cyc < 4096) check("cpu_stall", cpu_stall, exp_stall[cyc]);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;

    // Reset state.
    @(posedge clk);
    #1 abort_req = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Frame with boundary records, then random records.
    fill_random();
    set_rec(0, 16'd10, 16'd20, 16'd30, 16'd40, 16'hF00F);
    set_rec(1, 16'hFFFB, 16'd5, 16'd3, 16'd0, 16'h1234);
    set_rec(2, 16'd2000, 16'd7, 16'd100, 16'd1, 16'hABCD);
    set_rec(3, 16'd3, 16'h7FFF, 16'd1, 16'hFFFF, 16'h5A5A);
    pulse_frame();

    // start held high: one transfer per IDLE entry, back to back.
    fill_random();
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    expect_frame(s);
    expect_frame(s + NW + 4);
    repeat (2 * NW + 6) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in the middle of a transfer.
    fill_random();
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    expect_frame(s);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    for (int unsigned t = s + 21; t <= s + NW + 3; t++) exp_stall[t] = 1'b0;
    @(posedge clk);
    #1 abort_req = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (NW) @(negedge clk);

    // Clean transfer after the abort.
    fill_random();
    pulse_frame();

    repeat (4) @(negedge clk);
    check("leftover_words", exp_w.size(), 0);
    check("leftover_reads", exp_a.size(), 0);
    check("leftover_copy_start", exp_cs.size(), 0);
    check("leftover_done", exp_d.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
